// File: rtl/vid_timing_gen_pkg.sv
// vid_pkg: shared types and constants for the video timing generator.
//   rgb_t          - 24-bit packed pixel, r in [23:16], g in [15:8], b in [7:0]
//   region_e       - position of a counter within its line/frame
//   COLORBAR_TABLE - eight test-pattern colours, left to right
//   bar_colour()   - table lookup by bar index
package vid_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FP,
    REG_SYNC,
    REG_BP
  } region_e;

  localparam int unsigned NUM_BARS = 8;

  localparam logic [0:NUM_BARS-1][23:0] COLORBAR_TABLE = '{
    24'hFFFFFF,  // white
    24'hFFFF00,  // yellow
    24'h00FFFF,  // cyan
    24'h00FF00,  // green
    24'hFF00FF,  // magenta
    24'hFF0000,  // red
    24'h0000FF,  // blue
    24'h000000   // black
  };

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    return rgb_t'(COLORBAR_TABLE[idx]);
  endfunction

endpackage

// File: rtl/vid_timing_gen_if.sv
// vid_timing_gen_if: pixel-request and video-output bundle of vid_timing_gen.
//   req_o/x_o/y_o  - per-pixel request to the upstream source (stage 0)
//   pix_i          - pixel returned by the source one cycle after the request
//   data_o/vde_o/hsync_o/vsync_o/frame_start_o - aligned video stream
// Modports: master = timing generator, slave = source/sink side.
interface vid_timing_gen_if;
  import vid_pkg::*;

  logic        req_o;
  logic [11:0] x_o;
  logic [10:0] y_o;
  rgb_t        pix_i;
  rgb_t        data_o;
  logic        vde_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        frame_start_o;

  modport master (
    output req_o, x_o, y_o, data_o, vde_o, hsync_o, vsync_o, frame_start_o,
    input  pix_i
  );

  modport slave (
    input  req_o, x_o, y_o, data_o, vde_o, hsync_o, vsync_o, frame_start_o,
    output pix_i
  );

endinterface

// File: rtl/vtg_axis_cnt.sv
// vtg_axis_cnt: one timing axis (horizontal or vertical).
//   clk    - pixel clock
//   rst_n  - synchronous reset, active-low
//   step   - advance the counter this cycle
//   cnt    - current position, 0..TOTAL-1
//   wrap   - high when the counter steps from TOTAL-1 back to 0
//   active - position lies in the active region
//   sync   - position lies in the (active-high) sync region
// Regions are ordered active, front porch, sync, back porch.
module vtg_axis_cnt
  import vid_pkg::*;
#(
  parameter int unsigned TOTAL  = 1650,
  parameter int unsigned ACTIVE = 1280,
  parameter int unsigned FP     = 110,
  parameter int unsigned SYNC   = 40,
  parameter int unsigned W      = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
  localparam logic [W-1:0] FP_END   = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] r_cnt;
  region_e      w_region;
  logic         w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (step) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

  always_comb begin
    w_region = REG_BP;
    if (r_cnt < ACT_END) begin
      w_region = REG_ACTIVE;
    end else if (r_cnt < FP_END) begin
      w_region = REG_FP;
    end else if (r_cnt < SYNC_END) begin
      w_region = REG_SYNC;
    end
  end

  assign cnt    = r_cnt;
  assign wrap   = step && w_last;
  assign active = (w_region == REG_ACTIVE);
  assign sync   = (w_region == REG_SYNC);

endmodule

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: video timing source producing a 24-bit RGB stream with
// vde/hsync/vsync/frame_start, plus a per-pixel request to an upstream source.
//   clk   - pixel clock
//   rst_n - synchronous reset, active-low
//   bus   - vid_timing_gen_if.master (req_o, x_o, y_o, pix_i, data_o, vde_o,
//           hsync_o, vsync_o, frame_start_o)
// Pipeline: stage 0 = counters/request, stage 1 = timing registered while the
// source answers, stage 2 = output registers. All outputs lag the counters by 2.
// Build option: define VTG_COLORBAR_EN to replace pix_i with 8 vertical
// colour bars (white..black), each H_ACTIVE/8 wide, last bar takes remainder.
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  vid_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = 12;
  localparam int unsigned YW      = 11;

  logic [XW-1:0] w_h_cnt;
  logic [YW-1:0] w_v_cnt;
  logic          w_h_wrap, w_v_wrap;
  logic          w_h_act, w_v_act;
  logic          w_h_sync, w_v_sync;
  logic          w_vde;

  // Stage 1 / stage 2 registers (timing kept active-high internally)
  logic r_vde_d1, r_hs_d1, r_vs_d1, r_fs_d1;
  logic r_vde, r_hs, r_vs, r_fs;
  rgb_t r_data;

  // Set when the counters sit at (0,0): after reset and after each frame wrap.
  // Replaces a full compare of both counters against zero.
  logic r_fs_pend;

  vtg_axis_cnt #(
    .TOTAL  (H_TOTAL),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .W      (XW)
  ) u_h_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (1'b1),
    .cnt    (w_h_cnt),
    .wrap   (w_h_wrap),
    .active (w_h_act),
    .sync   (w_h_sync)
  );

  // v advances only on an h wrap, so vsync edges land on h_cnt == 0
  vtg_axis_cnt #(
    .TOTAL  (V_TOTAL),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .W      (YW)
  ) u_v_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (w_h_wrap),
    .cnt    (w_v_cnt),
    .wrap   (w_v_wrap),
    .active (w_v_act),
    .sync   (w_v_sync)
  );

  assign w_vde = w_h_act && w_v_act;

  // Stage 0: request straight from the counter registers
  assign bus.req_o = rst_n && w_vde;
  assign bus.x_o   = w_h_cnt;
  assign bus.y_o   = w_v_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fs_pend <= 1'b1;
    end else begin
      r_fs_pend <= w_v_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vde_d1 <= 1'b0;
      r_hs_d1  <= 1'b0;
      r_vs_d1  <= 1'b0;
      r_fs_d1  <= 1'b0;
      r_vde    <= 1'b0;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
      r_fs     <= 1'b0;
    end else begin
      r_vde_d1 <= w_vde;
      r_hs_d1  <= w_h_sync;
      r_vs_d1  <= w_v_sync;
      r_fs_d1  <= r_fs_pend;
      r_vde    <= r_vde_d1;
      r_hs     <= r_hs_d1;
      r_vs     <= r_vs_d1;
      r_fs     <= r_fs_d1;
    end
  end

`ifdef VTG_COLORBAR_EN
  localparam int unsigned BAR_W = (H_ACTIVE / NUM_BARS > 0) ? H_ACTIVE / NUM_BARS : 1;

  logic [XW-1:0] w_bar_q;
  logic [2:0]    w_bar_idx;
  rgb_t          r_bar_d1;

  // Quotient saturates at the last bar so it absorbs any remainder
  assign w_bar_q   = w_h_cnt / XW'(BAR_W);
  assign w_bar_idx = (w_bar_q > XW'(NUM_BARS - 1)) ? 3'(NUM_BARS - 1) : w_bar_q[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bar_d1 <= '0;
      r_data   <= '0;
    end else begin
      r_bar_d1 <= bar_colour(w_bar_idx);
      r_data   <= r_vde_d1 ? r_bar_d1 : '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      r_data <= r_vde_d1 ? bus.pix_i : '0;
    end
  end
`endif

  assign bus.data_o        = r_data;
  assign bus.vde_o         = r_vde;
  assign bus.frame_start_o = r_fs;
  assign bus.hsync_o       = r_hs ^ ~HS_POL;
  assign bus.vsync_o       = r_vs ^ ~VS_POL;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Scoreboard bench for vid_timing_gen with small geometry
// (H 8/2/2/2 -> 14 per line, V 4/1/1/1 -> 7 lines, 98 cycles per frame).
// A second instance with inverted sync polarity runs in lockstep.
module tb_vid_timing_gen;
  import vid_pkg::*;

  localparam int unsigned HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int unsigned VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = 14;
  localparam int unsigned FT = 98;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vid_timing_gen_if bus();
  vid_timing_gen_if bus_n();

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  typedef struct packed {
    logic        req;
    logic [11:0] x;
    logic [10:0] y;
    logic        vde;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  exp_t        tq[$];
  logic [23:0] pq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          started  = 1'b0;
  int unsigned k        = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected outputs after the k-th rising edge since reset release:
  // outputs show frame position k-1, the request shows position k+1.
  function automatic exp_t model(input logic rst_low, input int unsigned kk);
    exp_t        e;
    int unsigned p, h, v, q, qh, qv;
    e = '0;
    if (!rst_low) begin
      q     = (kk + 1) % FT;
      qh    = q % HT;
      qv    = q / HT;
      e.req = (qh < HA) && (qv < VA);
      e.x   = 12'(qh);
      e.y   = 11'(qv);
      if (kk >= 1) begin
        p     = (kk - 1) % FT;
        h     = p % HT;
        v     = p / HT;
        e.vde = (h < HA) && (v < VA);
        e.hs  = (h >= HA + HF) && (h < HA + HF + HS);
        e.vs  = (v >= VA + VF) && (v < VA + VF + VS);
        e.fs  = (p == 0);
      end
    end
    return e;
  endfunction

  function automatic logic [23:0] pix_model(input int unsigned kk);
    int unsigned p, h, v;
    logic [23:0] r;
    p = (kk - 1) % FT;
    h = p % HT;
    v = p / HT;
`ifdef VTG_COLORBAR_EN
    v = 0;
    case (h)
      0:       r = 24'hFFFFFF;
      1:       r = 24'hFFFF00;
      2:       r = 24'h00FFFF;
      3:       r = 24'h00FF00;
      4:       r = 24'hFF00FF;
      5:       r = 24'hFF0000;
      6:       r = 24'h0000FF;
      default: r = 24'h000000;
    endcase
`else
    r = {1'b0, 11'(v), 12'(h)};
`endif
    return r;
  endfunction

  // Drive rst_n for the coming edge and queue what that edge must produce
  task automatic step_cycle(input logic rst);
    exp_t e;
    @(negedge clk);
    rst_n   = rst;
    started = 1'b1;
    if (!rst) begin
      e = model(1'b1, 0);
      k = 0;
    end else begin
      e = model(1'b0, k);
      if (e.vde) pq.push_back(pix_model(k));
      k++;
    end
    tq.push_back(e);
  endtask

  // Upstream source: answers the request seen at the edge, one cycle later
  logic        src_req;
  logic [11:0] src_x;
  logic [10:0] src_y;
  always @(posedge clk) begin
    src_req = bus.req_o;
    src_x   = bus.x_o;
    src_y   = bus.y_o;
    #1;
    bus.pix_i = src_req ? rgb_t'({1'b0, src_y, src_x}) : rgb_t'(24'hA5A5A5);
  end

  // Monitor
  exp_t        me;
  int unsigned cyc_fs   = 0;
  int unsigned vde_cnt  = 0;
  int unsigned vs_run   = 0;
  bit          have_fs  = 1'b0;

  always @(posedge clk) begin
    #2;
    if (tq.size() == 0) begin
      if (started) begin
        n_checks++;
        n_fail++;
        $display("FAIL tq_underflow @%0t: got empty expected entry", $time);
      end
    end else begin
      me = tq.pop_front();
      chk1("vde", bus.vde_o, me.vde);
      chk1("hsync", bus.hsync_o, me.hs);
      chk1("vsync", bus.vsync_o, me.vs);
      chk1("frame_start", bus.frame_start_o, me.fs);
      chk1("req", bus.req_o, me.req);
      if (me.req) begin
        chkv("x", 24'(bus.x_o), 24'(me.x));
        chkv("y", 24'(bus.y_o), 24'(me.y));
      end
      if (!me.vde) chkv("data_blank", bus.data_o, 24'h0);
      chk1("hsync_n", bus_n.hsync_o, ~me.hs);
      chk1("vsync_n", bus_n.vsync_o, ~me.vs);

      if (bus.vde_o) begin
        if (pq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pix_underflow @%0t: got data %h expected none", $time, bus.data_o);
        end else begin
          chkv("pixel", bus.data_o, pq.pop_front());
        end
      end
    end

    if (!rst_n) begin
      have_fs = 1'b0;
      vs_run  = 0;
      cyc_fs  = 0;
      vde_cnt = 0;
    end else begin
      cyc_fs++;
      if (bus.frame_start_o) begin
        if (have_fs) begin
          chkv("fs_spacing", 24'(cyc_fs), 24'd98);
          chkv("vde_per_frame", 24'(vde_cnt), 24'd32);
        end
        have_fs = 1'b1;
        cyc_fs  = 0;
        vde_cnt = 0;
      end
      if (bus.vde_o) vde_cnt++;
      if (bus.vsync_o) begin
        vs_run++;
      end else if (vs_run != 0) begin
        chkv("vsync_run", 24'(vs_run), 24'd14);
        vs_run = 0;
      end
    end
  end

  initial begin
    bus.pix_i   = '0;
    bus_n.pix_i = '0;
    repeat (4) step_cycle(1'b0);
    // three full frames, stopping with the counters at line 2 pixel 3
    for (int i = 0; i < 3 * FT + 31; i++) step_cycle(1'b1);
    repeat (5) step_cycle(1'b0);
    for (int i = 0; i < 2 * FT + 10; i++) step_cycle(1'b1);
    @(posedge clk);
    #3;
    chkv("tq_drained", 24'(tq.size()), 24'd0);
    chkv("pq_drained", 24'(pq.size()), 24'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
